// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host byte receiver with ps2clk glitch filter, frame
// watchdog and a 3-byte mouse packet assembler on top of the byte stream.
module ps2_rx #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 200_000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       en_i,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_err_o,
    output logic       busy_o,
    output logic       pkt_valid_o,
    output logic [2:0] pkt_btn_o,
    output logic [8:0] pkt_dx_o,
    output logic [8:0] pkt_dy_o,
    output logic       pkt_xovf_o,
    output logic       pkt_yovf_o
);

    localparam int unsigned FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    if (CLK_HZ == 0 || FILTER_LEN < 1 || TIMEOUT_CYC < 2) begin : gBadParam
        $error("ps2_rx: CLK_HZ, FILTER_LEN or TIMEOUT_CYC out of range");
    end

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rxState_e;

    logic [2:0]      clkSync_q;
    logic [2:0]      dataSync_q;
    logic            filtLvl_q;
    logic            filtLvl_d;
    logic            filtPrev_q;
    logic [FC_W-1:0] filtCnt_q;
    logic [FC_W-1:0] filtCnt_d;
    logic            fallEdge;
    logic            dataBit;

    rxState_e        state_q;
    rxState_e        state_d;
    logic [2:0]      bitCnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [WD_W-1:0] wdCnt_q;
    logic            timeout;

    logic            busy;
    logic            stopEdge;
    logic            frameGood;
    logic            rxValid_d;
    logic            rxErr_d;
    logic [7:0]      rxData_d;
    logic            rxValid_q;
    logic            rxErr_q;
    logic [7:0]      rxData_q;

    logic [1:0]      pktIdx_q;
    logic [7:0]      byte0_q;
    logic [7:0]      byte1_q;
    logic [WD_W-1:0] idleCnt_q;
    logic            idleTimeout;
    logic            pktValid_q;
    logic [2:0]      pktBtn_q;
    logic [8:0]      pktDx_q;
    logic [8:0]      pktDy_q;
    logic            pktXovf_q;
    logic            pktYovf_q;

    // Both lines idle high, so the synchronizers and filter reset to 1.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            clkSync_q  <= '1;
            dataSync_q <= '1;
            filtLvl_q  <= 1'b1;
            filtPrev_q <= 1'b1;
            filtCnt_q  <= '0;
        end else begin
            clkSync_q  <= {clkSync_q[1:0], ps2clk_i};
            dataSync_q <= {dataSync_q[1:0], ps2data_i};
            filtLvl_q  <= filtLvl_d;
            filtPrev_q <= filtLvl_q;
            filtCnt_q  <= filtCnt_d;
        end
    end

    always_comb begin
        filtLvl_d = filtLvl_q;
        filtCnt_d = '0;
        if (clkSync_q[2] != filtLvl_q) begin
            if (filtCnt_q == FC_W'(FILTER_LEN - 1)) begin
                filtLvl_d = clkSync_q[2];
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
    end

    assign fallEdge = filtPrev_q & ~filtLvl_q;
    assign dataBit  = dataSync_q[2];
    assign timeout  = en_i && (state_q != RX_IDLE) && !fallEdge &&
                      (wdCnt_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_i || timeout) begin
            state_d = RX_IDLE;
        end else if (fallEdge) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (!dataBit) begin
                        state_d = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (bitCnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: state_d = RX_STOP;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    always_comb begin
        busy      = (state_q != RX_IDLE);
        stopEdge  = en_i && fallEdge && (state_q == RX_STOP);
        frameGood = stopEdge && dataBit && (^{shift_q, parity_q});
        rxValid_d = frameGood;
        rxErr_d   = (stopEdge && !frameGood) || timeout;
        rxData_d  = frameGood ? shift_q : rxData_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bitCnt_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            wdCnt_q   <= '0;
            rxValid_q <= 1'b0;
            rxErr_q   <= 1'b0;
            rxData_q  <= '0;
        end else begin
            rxValid_q <= rxValid_d;
            rxErr_q   <= rxErr_d;
            rxData_q  <= rxData_d;

            if (state_q == RX_IDLE || !en_i || fallEdge) begin
                wdCnt_q <= '0;
            end else if (!timeout) begin
                wdCnt_q <= wdCnt_q + 1'b1;
            end

            if (state_q == RX_IDLE) begin
                bitCnt_q <= '0;
            end else if (fallEdge && state_q == RX_DATA) begin
                shift_q  <= {dataBit, shift_q[7:1]};
                bitCnt_q <= bitCnt_q + 1'b1;
            end

            if (fallEdge && state_q == RX_PARITY) begin
                parity_q <= dataBit;
            end
        end
    end

    // A long idle gap mid-packet means the mouse stream was lost; resync.
    assign idleTimeout = (state_q == RX_IDLE) && (pktIdx_q != 2'd0) &&
                         (idleCnt_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            idleCnt_q <= '0;
        end else if (state_q != RX_IDLE || pktIdx_q == 2'd0 || idleTimeout) begin
            idleCnt_q <= '0;
        end else begin
            idleCnt_q <= idleCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pktIdx_q   <= '0;
            byte0_q    <= '0;
            byte1_q    <= '0;
            pktValid_q <= 1'b0;
            pktBtn_q   <= '0;
            pktDx_q    <= '0;
            pktDy_q    <= '0;
            pktXovf_q  <= 1'b0;
            pktYovf_q  <= 1'b0;
        end else begin
            pktValid_q <= 1'b0;
            if (!en_i || rxErr_q || idleTimeout) begin
                pktIdx_q <= '0;
            end else if (rxValid_q) begin
                unique case (pktIdx_q)
                    2'd0: begin
                        if (rxData_q[3]) begin
                            byte0_q  <= rxData_q;
                            pktIdx_q <= 2'd1;
                        end
                    end
                    2'd1: begin
                        byte1_q  <= rxData_q;
                        pktIdx_q <= 2'd2;
                    end
                    default: begin
                        pktBtn_q   <= byte0_q[2:0];
                        pktDx_q    <= {byte0_q[4], byte1_q};
                        pktDy_q    <= {byte0_q[5], rxData_q};
                        pktXovf_q  <= byte0_q[6];
                        pktYovf_q  <= byte0_q[7];
                        pktValid_q <= 1'b1;
                        pktIdx_q   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign rx_data_o   = rxData_q;
    assign rx_valid_o  = rxValid_q;
    assign rx_err_o    = rxErr_q;
    assign busy_o      = busy;
    assign pkt_valid_o = pktValid_q;
    assign pkt_btn_o   = pktBtn_q;
    assign pkt_dx_o    = pktDx_q;
    assign pkt_dy_o    = pktDy_q;
    assign pkt_xovf_o  = pktXovf_q;
    assign pkt_yovf_o  = pktYovf_q;

endmodule
